camera_wr_packer: RTL

- Sits directly upstream of the DDR request arbiter on the camera write port.
- Accepts a stream of 16-bit camera pixels, already in the 133 MHz domain, and packs 8 pixels into one 128-bit word.
- Tags each word with a DDR word address and queues it in a small FIFO.
- Drives the camera_wr_req/camera_ack handshake to the arbiter, one word per request.

---
 rtl/camera_wr_packer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/camera_wr_packer.sv
// camera_wr_packer: packs 16-bit camera pixels eight at a time into 128-bit
// DDR words. Each word is tagged with its frame-buffer address, queued in a
// small FIFO and offered to the DDR arbiter over camera_wr_req/camera_ack.
// Optional feature macro: CAMERA_FRAME_SWAP_EN. When defined, successive frames
// alternate between BASE_A and BASE_B. Otherwise every frame uses BASE_A.
module camera_wr_packer #(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          WORDS_PER_FRAME = 38400,
    parameter int          ADDR_STEP       = 8,
    parameter logic [24:0] BASE_A          = 25'h0000000,
    parameter logic [24:0] BASE_B          = 25'h0100000
) (
    input  logic                          clk_133M,
    input  logic                          rst_n_133M,
    input  logic                          frame_start,
    input  logic [15:0]                   pix_data,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic                          camera_wr_req,
    output logic [24:0]                   camera_wr_address,
    output logic [127:0]                  camera_wr_data,
    input  logic                          camera_ack,
    output logic                          frame_done,
    output logic                          frame_sel,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int IDX_W   = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int ENTRY_W = 25 + 128;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Packing state
    logic [2:0]       r_lane;
    logic [IDX_W-1:0] r_word_idx;
    logic [111:0]     r_pack;       // lanes 0..6 of the word being assembled

    // FIFO state
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_count;
    logic [LVL_W-1:0]   r_drain_left;   // pops remaining until the frame's last word leaves

    logic r_overflow;
    logic r_frame_done;

    // Datapath wires
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pix_acc;
    logic               w_in_frame;
    logic               w_pack;
    logic [2:0]         w_lane;
    logic [IDX_W-1:0]   w_idx;
    logic               w_push;
    logic               w_last_word;
    logic               w_pop;
    logic               w_frame_end;
    logic [24:0]        w_base;
    logic [24:0]        w_addr;
    logic [ENTRY_W-1:0] w_head;
    logic [LVL_W-1:0]   w_level_nxt;

    assign w_fifo_full  = (r_count == LVL_W'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);

    // A pixel is consumed whenever ready; it is packed only inside a frame.
    // frame_start takes effect in the same cycle, so a coincident pixel
    // becomes lane 0 of the new frame.
    assign w_pix_acc   = pix_valid && !w_fifo_full;
    assign w_in_frame  = frame_start || (r_state == S_ACTIVE);
    assign w_pack      = w_pix_acc && w_in_frame;
    assign w_lane      = frame_start ? 3'd0 : r_lane;
    assign w_idx       = frame_start ? '0 : r_word_idx;
    assign w_push      = w_pack && (w_lane == 3'd7);
    assign w_last_word = w_push && (w_idx == IDX_W'(WORDS_PER_FRAME - 1));

    // Ack without a pending request is ignored.
    assign w_pop       = camera_ack && !w_fifo_empty;
    assign w_frame_end = (r_state == S_DRAIN) && w_pop && (r_drain_left == LVL_W'(1));

`ifdef CAMERA_FRAME_SWAP_EN
    logic r_cur_sel;    // buffer of the frame being captured
    logic r_next_sel;   // buffer the next frame_start will select
    logic r_frame_sel;
    logic w_sel;

    assign w_sel     = frame_start ? r_next_sel : r_cur_sel;
    assign w_base    = w_sel ? BASE_B : BASE_A;
    assign frame_sel = r_frame_sel;

    // Buffer selection: the first frame after reset uses A, then every
    // frame_start (aborted frames included) alternates.
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            r_cur_sel   <= 1'b0;
            r_next_sel  <= 1'b0;
            r_frame_sel <= 1'b0;
        end else begin
            if (frame_start) begin
                r_cur_sel  <= r_next_sel;
                r_next_sel <= ~r_next_sel;
            end
            if (w_frame_end) begin
                r_frame_sel <= r_cur_sel;
            end
        end
    end
`else
    logic [24:0] w_unused_base_b;

    assign w_unused_base_b = BASE_B;
    assign w_base          = BASE_A;
    assign frame_sel       = 1'b0;
`endif

    // Address arithmetic wraps modulo 2^25.
    assign w_addr = w_base + (25'(w_idx) * 25'(ADDR_STEP));

    // Frame state register
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n_133M) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame next-state: frame_start always (re)starts a frame
    always_comb begin
        // NOTE: default first so no path leaves w_state_nxt unassigned,
        // which would otherwise infer a latch.
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = S_ACTIVE;
        end else begin
            case (r_state)
                S_ACTIVE: if (w_last_word) w_state_nxt = S_DRAIN;
                S_DRAIN:  if (w_frame_end) w_state_nxt = S_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Lane and word counters plus the partial-word holding register
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            r_lane     <= 3'd0;
            r_word_idx <= '0;
            r_pack     <= '0;
        end else begin
            if (frame_start) begin
                r_lane     <= 3'd0;
                r_word_idx <= '0;
            end
            if (w_pack) begin
                if (w_push) begin
                    r_lane     <= 3'd0;
                    r_word_idx <= w_last_word ? '0 : (w_idx + IDX_W'(1));
                end else begin
                    r_pack[{w_lane, 4'b0000} +: 16] <= pix_data;
                    r_lane                          <= w_lane + 3'd1;
                end
            end
        end
    end

    // FIFO storage: address and data pushed together
    always_ff @(posedge clk_133M) begin
        // NOTE: storage is left unreset; entries are only read once written,
        // and the head is masked to zero while the FIFO is empty.
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_addr, pix_data, r_pack};
        end
    end

    // Level after this cycle's push and pop
    always_comb begin
        w_level_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_count + LVL_W'(1);
            2'b01:   w_level_nxt = r_count - LVL_W'(1);
            default: w_level_nxt = r_count;
        endcase
    end

    // FIFO pointers, level and last-word tracking
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drain_left <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_level_nxt;
            // The last word sits at the tail, so it leaves after
            // exactly as many pops as the level following its push.
            if (w_last_word) begin
                r_drain_left <= w_level_nxt;
            end else if (w_pop && (r_drain_left != '0)) begin
                r_drain_left <= r_drain_left - LVL_W'(1);
            end
        end
    end

    // Sticky overflow and the frame-complete pulse
    always_ff @(posedge clk_133M or negedge rst_n_133M) begin
        if (!rst_n_133M) begin
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (pix_valid && w_fifo_full && w_in_frame) begin
                r_overflow <= 1'b1;
            end
            r_frame_done <= w_frame_end;
        end
    end

    assign w_head            = r_mem[r_rd_ptr];
    assign pix_ready         = !w_fifo_full;
    assign camera_wr_req     = !w_fifo_empty;
    assign camera_wr_address = w_fifo_empty ? 25'd0  : w_head[ENTRY_W-1 -: 25];
    assign camera_wr_data    = w_fifo_empty ? 128'd0 : w_head[127:0];
    assign frame_done        = r_frame_done;
    assign overflow          = r_overflow;
    assign fifo_level        = r_count;

endmodule
